map_discrete_bank: RTL

//  Parametrised successor of the fixed NROM mapper: one 8-bit bank register written by CPU stores to $8000-$FFFF.

---
 rtl/map_discrete_bank_pkg.sv | 17 +
 rtl/map_discrete_bank_if.sv | 49 ++++
 rtl/map_discrete_bank_m2_wr_det.sv | 86 ++++++++
 rtl/map_discrete_bank.sv | 97 +++++++++
 4 files changed

// File: rtl/map_discrete_bank_pkg.sv
// Shared constants for the discrete-logic bank mapper: mode codes, write-FSM
// encodings and save-state addresses.
package map_discrete_bank_pkg;

   localparam int MODE_UXROM = 0;
   localparam int MODE_CNROM = 1;
   localparam int MODE_GXROM = 2;
   localparam int MODE_AXROM = 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   localparam logic [7:0] SS_ADDR_BANK = 8'd0;
   localparam logic [7:0] SS_ADDR_IDX  = 8'd127;

endpackage

// File: rtl/map_discrete_bank_if.sv
// Cartridge-side bus bundle for map_discrete_bank: CPU/PPU inputs, save-state
// port and the PRG/CHR/SRAM/CIRAM address and strobe outputs.
interface map_discrete_bank_if #(
   parameter int PRG_AW = 19,
   parameter int CHR_AW = 17
);
   logic              m2;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_dat;
   logic              cpu_rw;
   logic [7:0]        prg_dat;
   logic [13:0]       ppu_addr;
   logic              ppu_oe;
   logic              ppu_we;
   logic              cfg_mir_v;
   logic              cfg_chr_ram;
   logic              ss_we;
   logic [7:0]        ss_addr;
   logic [7:0]        ss_wdat;
   logic [7:0]        ss_rdat;
   logic [PRG_AW-1:0] prg_addr;
   logic [CHR_AW-1:0] chr_addr;
   logic [12:0]       srm_addr;
   logic              rom_ce;
   logic              ram_ce;
   logic              ram_we;
   logic              prg_oe;
   logic              chr_ce;
   logic              chr_we;
   logic              chr_oe;
   logic              ciram_ce;
   logic              ciram_a10;
   logic [7:0]        bank_q;

   modport slave (
      input  m2, cpu_addr, cpu_dat, cpu_rw, prg_dat, ppu_addr, ppu_oe, ppu_we,
             cfg_mir_v, cfg_chr_ram, ss_we, ss_addr, ss_wdat,
      output ss_rdat, prg_addr, chr_addr, srm_addr, rom_ce, ram_ce, ram_we,
             prg_oe, chr_ce, chr_we, chr_oe, ciram_ce, ciram_a10, bank_q
   );

   modport master (
      output m2, cpu_addr, cpu_dat, cpu_rw, prg_dat, ppu_addr, ppu_oe, ppu_we,
             cfg_mir_v, cfg_chr_ram, ss_we, ss_addr, ss_wdat,
      input  ss_rdat, prg_addr, chr_addr, srm_addr, rom_ce, ram_ce, ram_we,
             prg_oe, chr_ce, chr_we, chr_oe, ciram_ce, ciram_a10, bank_q
   );

endinterface

// File: rtl/map_discrete_bank_m2_wr_det.sv
// M2 synchroniser and CPU-store detector; emits one wr_stb_o per qualifying M2
// cycle. MAP_DSCR_BUS_CONFLICT_EN: committed data is ANDed with PRG ROM data.
//
// state  | meaning
// IDLE   | waiting for M2 rise with a CPU store to $8000-$FFFF
// ARMED  | store in progress, latching data while M2 high
// COMMIT | wr_stb_o asserted for one clk, then back to IDLE
module map_discrete_bank_m2_wr_det
   import map_discrete_bank_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       m2_i,
   input  logic       cpu_a15_i,
   input  logic       cpu_rw_i,
   input  logic [7:0] cpu_dat_i,
   input  logic [7:0] prg_dat_i,
   input  logic       ss_clr_i,
   output logic       wr_stb_o,
   output logic [7:0] wr_dat_o
);

   logic       m2_s1_q, m2_s_q, m2_prev_q;
   logic [1:0] state_q, state_d;
   logic [7:0] wdat_q, wdat_d;
   logic [7:0] pdat_q, pdat_d;
   logic       m2_rise, m2_fall;

   assign m2_rise = m2_s_q & ~m2_prev_q;
   assign m2_fall = ~m2_s_q & m2_prev_q;

   always_comb begin
      state_d = state_q;
      wdat_d  = wdat_q;
      pdat_d  = pdat_q;
      case (state_q)
         ST_IDLE: begin
            if (m2_rise && !cpu_rw_i && cpu_a15_i) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (m2_fall) begin
               state_d = ST_COMMIT;
            end else if (m2_s_q) begin
               if (cpu_rw_i || !cpu_a15_i) begin
                  state_d = ST_IDLE;
               end else begin
                  wdat_d = cpu_dat_i;
                  pdat_d = prg_dat_i;
               end
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (ss_clr_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m2_s1_q   <= 1'b0;
         m2_s_q    <= 1'b0;
         m2_prev_q <= 1'b0;
         state_q   <= ST_IDLE;
         wdat_q    <= 8'h00;
         pdat_q    <= 8'h00;
      end else begin
         m2_s1_q   <= m2_i;
         m2_s_q    <= m2_s1_q;
         m2_prev_q <= m2_s_q;
         state_q   <= state_d;
         wdat_q    <= wdat_d;
         pdat_q    <= pdat_d;
      end
   end

   assign wr_stb_o = (state_q == ST_COMMIT);

`ifdef MAP_DSCR_BUS_CONFLICT_EN
   assign wr_dat_o = wdat_q & pdat_q;
`else
   logic unused_pdat;
   assign unused_pdat = ^pdat_q;
   assign wr_dat_o    = wdat_q;
`endif

endmodule

// File: rtl/map_discrete_bank.sv
// Discrete-logic bank mapper (UxROM/CNROM/GxROM/AxROM by MODE) with M2 store
// detection and save-state access. Optional macro: MAP_DSCR_BUS_CONFLICT_EN.
module map_discrete_bank
   import map_discrete_bank_pkg::*;
#(
   parameter int         MODE    = 0,
   parameter int         PRG_AW  = 19,
   parameter int         CHR_AW  = 17,
   parameter logic [7:0] MAP_IDX = 8'd2
) (
   input logic            clk,
   input logic            map_rst,
   map_discrete_bank_if.slave bus
);

   logic [7:0]        bank_q, bank_d;
   logic              wr_stb;
   logic [7:0]        wr_dat;
   logic              ss_bank_we;
   logic [PRG_AW-1:0] prg_sel;
   logic [CHR_AW-1:0] chr_sel;
   logic              a10_sel;
   logic              ciram_ce;

   assign ss_bank_we = bus.ss_we && (bus.ss_addr == SS_ADDR_BANK);

   map_discrete_bank_m2_wr_det u_wr_det (
      .clk       (clk),
      .rst       (map_rst),
      .m2_i      (bus.m2),
      .cpu_a15_i (bus.cpu_addr[15]),
      .cpu_rw_i  (bus.cpu_rw),
      .cpu_dat_i (bus.cpu_dat),
      .prg_dat_i (bus.prg_dat),
      .ss_clr_i  (ss_bank_we),
      .wr_stb_o  (wr_stb),
      .wr_dat_o  (wr_dat)
   );

   // Save-state restore takes precedence over a store committing in the same clk.
   always_comb begin
      bank_d = bank_q;
      if (ss_bank_we)  bank_d = bus.ss_wdat;
      else if (wr_stb) bank_d = wr_dat;
   end

   always_ff @(posedge clk or posedge map_rst) begin
      if (map_rst) bank_q <= 8'h00;
      else         bank_q <= bank_d;
   end

   always_comb begin
      prg_sel = PRG_AW'(bus.cpu_addr[14:0]);
      chr_sel = CHR_AW'(bus.ppu_addr[12:0]);
      a10_sel = bus.cfg_mir_v ? bus.ppu_addr[10] : bus.ppu_addr[11];
      case (MODE)
         MODE_UXROM: begin
            // Upper 16K window is hard-wired to the last bank.
            if (bus.cpu_addr[14])
               prg_sel = PRG_AW'({{PRG_AW{1'b1}}, bus.cpu_addr[13:0]});
            else
               prg_sel = PRG_AW'({bank_q, bus.cpu_addr[13:0]});
         end
         MODE_CNROM: begin
            chr_sel = CHR_AW'({bank_q[1:0], bus.ppu_addr[12:0]});
         end
         MODE_GXROM: begin
            prg_sel = PRG_AW'({bank_q[5:4], bus.cpu_addr[14:0]});
            chr_sel = CHR_AW'({bank_q[1:0], bus.ppu_addr[12:0]});
         end
         MODE_AXROM: begin
            prg_sel = PRG_AW'({bank_q[2:0], bus.cpu_addr[14:0]});
            a10_sel = bank_q[4];
         end
         default: ;
      endcase
   end

   assign ciram_ce      = ~bus.ppu_addr[13];
   assign bus.prg_addr  = prg_sel;
   assign bus.chr_addr  = chr_sel;
   assign bus.ciram_a10 = a10_sel;
   assign bus.ciram_ce  = ciram_ce;
   assign bus.chr_ce    = ciram_ce;
   assign bus.chr_we    = bus.cfg_chr_ram & ~bus.ppu_we & ciram_ce;
   assign bus.chr_oe    = ~bus.ppu_oe;
   assign bus.srm_addr  = bus.cpu_addr[12:0];
   assign bus.rom_ce    = bus.cpu_addr[15];
   assign bus.ram_ce    = (bus.cpu_addr[15:13] == 3'b011);
   assign bus.ram_we    = ~bus.cpu_rw & (bus.cpu_addr[15:13] == 3'b011);
   assign bus.prg_oe    = bus.cpu_rw;
   assign bus.bank_q    = bank_q;

   assign bus.ss_rdat = (bus.ss_addr == SS_ADDR_BANK) ? bank_q  :
                        (bus.ss_addr == SS_ADDR_IDX)  ? MAP_IDX : 8'hFF;

endmodule
